// File: rtl/dlsc_pcie_s6_rx_decoder.sv
// Receive-side TLP decoder for the Spartan-6 PCIe TRN RX interface.
// Splits each TLP into a registered header channel and a payload stream; drops and counts bad TLPs.
module dlsc_pcie_s6_rx_decoder #(
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         trn_rd,
    input  logic                trn_rsof_n,
    input  logic                trn_reof_n,
    input  logic                trn_rsrc_rdy_n,
    input  logic                trn_rsrc_dsc_n,
    input  logic                trn_rerrfwd_n,
    input  logic [6:0]          trn_rbar_hit_n,
    output logic                trn_rdst_rdy_n,
    input  logic                hdr_ready,
    output logic                hdr_valid,
    output logic [1:0]          hdr_type,
    output logic [61:0]         hdr_addr,
    output logic [10:0]         hdr_len,
    output logic [7:0]          hdr_tag,
    output logic [15:0]         hdr_req_id,
    output logic [3:0]          hdr_be_first,
    output logic [3:0]          hdr_be_last,
    output logic [2:0]          hdr_bar,
    input  logic                data_ready,
    output logic                data_valid,
    output logic [31:0]         data,
    output logic                data_last,
    output logic                data_err,
    output logic [CNT_BITS-1:0] drop_count
);

    typedef enum logic [2:0] {S_IDLE, S_H1, S_H2, S_H3, S_HDR, S_DATA, S_DROP} state_t;

    localparam logic [4:0] TYPE_MEM = 5'b00000;
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    state_t      r_state, w_next;
    logic [1:0]  r_fmt;
    logic [4:0]  r_type;
    logic        r_poison;
    logic [10:0] r_cnt;

    logic w_src, w_sof, w_eof, w_dsc;
    logic w_in_tlp, w_sof_hold, w_abort, w_out_free, w_rdy, w_acc;
    logic w_sup, w_nodata, w_hdr_end;
    logic w_inc, w_load, w_ld_last, w_ld_err, w_dec;
    logic [2:0] w_bar;

    assign w_src      = !trn_rsrc_rdy_n;
    assign w_sof      = !trn_rsof_n;
    assign w_eof      = !trn_reof_n;
    assign w_dsc      = !trn_rsrc_dsc_n;
    assign w_in_tlp   = (r_state != S_IDLE) && (r_state != S_HDR);
    // A SOF mid-TLP terminates the current TLP; the SOF beat itself is held off for a cycle.
    assign w_sof_hold = w_src && w_sof && w_in_tlp;
    assign w_abort    = w_dsc || w_sof_hold;
    assign w_out_free = !data_valid || data_ready;
    assign w_sup      = ((r_type == TYPE_MEM) || ((r_type == TYPE_CPL) && !r_fmt[0])) && !r_poison;
    assign w_nodata   = !r_fmt[1];
    assign w_hdr_end  = (r_state == S_H3) || ((r_state == S_H2) && !r_fmt[0]);
    assign hdr_valid  = (r_state == S_HDR);

    always_comb begin
        w_bar = 3'd7;
        for (int unsigned i = 7; i > 0; i--) begin
            if (!trn_rbar_hit_n[i-1]) w_bar = 3'(i - 1);
        end
    end

    always_comb begin
        case (r_state)
            S_HDR:   w_rdy = 1'b0;
            S_DATA:  w_rdy = w_out_free && !w_sof_hold;
            default: w_rdy = !w_sof_hold;
        endcase
    end

    assign trn_rdst_rdy_n = rst || !w_rdy;
    assign w_acc          = w_src && w_rdy;

    always_comb begin
        w_next    = r_state;
        w_inc     = 1'b0;
        w_load    = 1'b0;
        w_ld_last = 1'b0;
        w_ld_err  = 1'b0;
        w_dec     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc && w_sof) begin
                    if (w_eof) w_inc  = 1'b1;
                    else       w_next = S_H1;
                end
            end
            S_H1, S_H2, S_H3: begin
                if (w_abort) begin
                    w_inc  = 1'b1;
                    w_next = S_IDLE;
                end else if (w_acc) begin
                    if (!w_hdr_end) begin
                        if (w_eof) begin
                            w_inc  = 1'b1;
                            w_next = S_IDLE;
                        end else begin
                            w_next = (r_state == S_H1) ? S_H2 : S_H3;
                        end
                    end else if (w_sup && (!w_eof || w_nodata)) begin
                        w_next = S_HDR;
                    end else begin
                        w_inc  = 1'b1;
                        w_next = w_eof ? S_IDLE : S_DROP;
                    end
                end
            end
            S_HDR: begin
                if (hdr_ready) w_next = w_nodata ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_out_free) begin
                    if (w_abort) begin
                        w_load    = 1'b1;
                        w_ld_last = 1'b1;
                        w_ld_err  = 1'b1;
                        w_inc     = 1'b1;
                        w_next    = S_IDLE;
                    end else if (w_acc) begin
                        w_load = 1'b1;
                        if (r_cnt == 11'd1) begin
                            w_ld_last = 1'b1;
                            if (w_eof) begin
                                w_next = S_IDLE;
                            end else begin
                                w_ld_err = 1'b1;
                                w_inc    = 1'b1;
                                w_next   = S_DROP;
                            end
                        end else if (w_eof) begin
                            w_ld_last = 1'b1;
                            w_ld_err  = 1'b1;
                            w_inc     = 1'b1;
                            w_next    = S_IDLE;
                        end else begin
                            w_dec = 1'b1;
                        end
                    end
                end
            end
            S_DROP: begin
                if (w_sof_hold || (w_acc && w_eof)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fmt        <= '0;
            r_type       <= '0;
            r_poison     <= 1'b0;
            r_cnt        <= '0;
            hdr_type     <= '0;
            hdr_addr     <= '0;
            hdr_len      <= '0;
            hdr_tag      <= '0;
            hdr_req_id   <= '0;
            hdr_be_first <= '0;
            hdr_be_last  <= '0;
            hdr_bar      <= 3'd7;
            data_valid   <= 1'b0;
            data         <= '0;
            data_last    <= 1'b0;
            data_err     <= 1'b0;
            drop_count   <= '0;
        end else begin
            r_state <= w_next;
            if (w_inc && (drop_count != '1)) drop_count <= drop_count + 1'b1;

            if (w_load) begin
                data_valid <= 1'b1;
                data       <= trn_rd;
                data_last  <= w_ld_last;
                data_err   <= w_ld_err;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end

            if ((r_state == S_HDR) && hdr_ready) r_cnt <= hdr_len;
            else if (w_dec)                      r_cnt <= r_cnt - 1'b1;

            // Completions carry tag and lower address in DW2, overriding the DW1 request fields.
            if (w_acc) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_sof) begin
                            r_fmt    <= trn_rd[30:29];
                            r_type   <= trn_rd[28:24];
                            r_poison <= !trn_rerrfwd_n;
                            hdr_type <= {trn_rd[28:24] == TYPE_CPL, trn_rd[30]};
                            hdr_len  <= {trn_rd[9:0] == 10'd0, trn_rd[9:0]};
                            hdr_bar  <= w_bar;
                        end
                    end
                    S_H1: begin
                        hdr_req_id   <= trn_rd[31:16];
                        hdr_tag      <= trn_rd[15:8];
                        hdr_be_last  <= trn_rd[7:4];
                        hdr_be_first <= trn_rd[3:0];
                    end
                    S_H2: begin
                        if (r_type == TYPE_CPL) begin
                            hdr_tag      <= trn_rd[15:8];
                            hdr_be_first <= trn_rd[3:0];
                            hdr_be_last  <= '0;
                            hdr_addr     <= '0;
                        end else if (r_fmt[0]) begin
                            hdr_addr[61:30] <= trn_rd;
                        end else begin
                            hdr_addr <= {32'd0, trn_rd[31:2]};
                        end
                    end
                    S_H3:    hdr_addr[29:0] <= trn_rd[31:2];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_rx_decoder.sv
// Directed bench for dlsc_pcie_s6_rx_decoder: TLP-level model predicts headers, payload beats and drops.
module tb_dlsc_pcie_s6_rx_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] trn_rd;
    logic        trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rsrc_dsc_n, trn_rerrfwd_n;
    logic [6:0]  trn_rbar_hit_n;
    logic        trn_rdst_rdy_n;
    logic        hdr_ready, hdr_valid;
    logic [1:0]  hdr_type;
    logic [61:0] hdr_addr;
    logic [10:0] hdr_len;
    logic [7:0]  hdr_tag;
    logic [15:0] hdr_req_id;
    logic [3:0]  hdr_be_first, hdr_be_last;
    logic [2:0]  hdr_bar;
    logic        data_ready, data_valid, data_last, data_err;
    logic [31:0] data;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    dlsc_pcie_s6_rx_decoder #(.CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .trn_rd(trn_rd), .trn_rsof_n(trn_rsof_n), .trn_reof_n(trn_reof_n),
        .trn_rsrc_rdy_n(trn_rsrc_rdy_n), .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rerrfwd_n(trn_rerrfwd_n),
        .trn_rbar_hit_n(trn_rbar_hit_n), .trn_rdst_rdy_n(trn_rdst_rdy_n), .hdr_ready(hdr_ready),
        .hdr_valid(hdr_valid), .hdr_type(hdr_type), .hdr_addr(hdr_addr), .hdr_len(hdr_len),
        .hdr_tag(hdr_tag), .hdr_req_id(hdr_req_id), .hdr_be_first(hdr_be_first),
        .hdr_be_last(hdr_be_last), .hdr_bar(hdr_bar), .data_ready(data_ready),
        .data_valid(data_valid), .data(data), .data_last(data_last), .data_err(data_err),
        .drop_count(drop_count)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [61:0] addr;
        bit          has_addr;
        logic [10:0] len;
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [3:0]  bf;
        logic [3:0]  bl;
        logic [2:0]  bar;
    } hexp_t;

    typedef struct {
        logic [31:0] d;
        bit          dc;
        bit          last;
        bit          err;
    } dexp_t;

    hexp_t       hq[$];
    dexp_t       dq[$];
    logic [31:0] tx[$];
    int          exp_drops = 0;
    int          checks = 0;
    int          failures = 0;
    bit          bp_mode = 1'b0;

    logic [1:0]  last_htype;
    logic [61:0] last_haddr;
    logic [10:0] last_hlen;
    logic [7:0]  last_htag;
    logic [2:0]  last_hbar;
    logic [31:0] last_data;
    logic        last_dlast, last_derr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat_drops();
        return (exp_drops > 65535) ? 65535 : exp_drops;
    endfunction

    // Expected outcome of the TLP in tx[], from the decoding rules alone.
    function automatic void predict(input bit eof_last, input int dsc_at, input logic [6:0] bar_n,
                                    input bit poison);
        logic [31:0] d0;
        int          hd, n, len_dw, np;
        bit          mem, cpl, found;
        hexp_t       h;
        dexp_t       e;
        n   = tx.size();
        d0  = tx[0];
        hd  = d0[29] ? 4 : 3;
        mem = (d0[28:24] == 5'b00000);
        cpl = (d0[28:24] == 5'b01010) && !d0[29];
        if (dsc_at > 0 && dsc_at < hd) begin exp_drops++; return; end
        if (n < hd) begin if (eof_last) exp_drops++; return; end
        if (!(mem || cpl) || poison || (d0[30] && n == hd && eof_last)) begin exp_drops++; return; end
        h.typ = {cpl, d0[30]};
        h.len = (d0[9:0] == 10'd0) ? 11'd1024 : {1'b0, d0[9:0]};
        h.rid = tx[1][31:16];
        if (cpl) begin
            h.tag = tx[2][15:8]; h.bf = tx[2][3:0]; h.bl = 4'h0; h.has_addr = 0; h.addr = '0;
        end else begin
            h.tag = tx[1][15:8]; h.bf = tx[1][3:0]; h.bl = tx[1][7:4]; h.has_addr = 1;
            h.addr = (hd == 4) ? {tx[2], tx[3][31:2]} : {32'h0, tx[2][31:2]};
        end
        h.bar = 3'd7;
        found = 0;
        for (int i = 0; i < 7; i++) if (!found && !bar_n[i]) begin h.bar = 3'(i); found = 1; end
        hq.push_back(h);
        if (!d0[30]) return;
        len_dw = int'(h.len);
        np = n - hd;
        for (int k = 0; hd + k < n; k++) begin
            e.d = tx[hd+k]; e.dc = 0; e.last = 0; e.err = 0;
            if (hd + k == dsc_at) begin
                e.dc = 1; e.last = 1; e.err = 1; exp_drops++; dq.push_back(e); return;
            end
            if (k == len_dw - 1) begin
                e.last = 1; e.err = !(eof_last && k == np - 1);
                if (e.err) exp_drops++;
                dq.push_back(e);
                return;
            end
            if (eof_last && k == np - 1) begin
                e.last = 1; e.err = 1; exp_drops++; dq.push_back(e); return;
            end
            dq.push_back(e);
        end
    endfunction

    task automatic idle_inputs();
        trn_rsrc_rdy_n = 1'b1; trn_rsof_n = 1'b1; trn_reof_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1; trn_rerrfwd_n = 1'b1; trn_rbar_hit_n = 7'h7F;
    endtask

    task automatic send(input bit eof_last, input int dsc_at, input logic [6:0] bar_n, input bit poison);
        int i = 0;
        int stall = 0;
        bit acc;
        predict(eof_last, dsc_at, bar_n, poison);
        while (i < tx.size()) begin
            trn_rd         = tx[i];
            trn_rsof_n     = (i != 0);
            trn_reof_n     = !(eof_last && i == tx.size() - 1);
            trn_rsrc_rdy_n = 1'b0;
            trn_rsrc_dsc_n = (i != dsc_at);
            trn_rbar_hit_n = bar_n;
            trn_rerrfwd_n  = !poison;
            @(negedge clk);
            acc = !trn_rdst_rdy_n;
            @(posedge clk);
            #1;
            if (acc) begin
                if (i == dsc_at) break;
                i++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 200) begin
                    chk("send_timeout", 64'(stall), 0);
                    break;
                end
            end
        end
        idle_inputs();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((hq.size() != 0 || dq.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hdr_left"}, 64'(hq.size()), 0);
        chk({tag, "_data_left"}, 64'(dq.size()), 0);
        chk({tag, "_drop_count"}, 64'(drop_count), 64'(sat_drops()));
    endtask

    // Compare process: every header/data handshake against the model, plus hold stability.
    hexp_t       ch;
    dexp_t       cd;
    logic        p_hv = 0, p_hr = 0, p_dv = 0, p_dr = 0;
    logic [61:0] p_addr;
    logic [31:0] p_data;

    always @(negedge clk) begin
        if (rst) begin
            p_hv <= 0; p_dv <= 0;
        end else begin
            if (p_hv && !p_hr) begin
                chk("hdr_hold_valid", 64'(hdr_valid), 1);
                chk("hdr_hold_addr", 64'(hdr_addr), 64'(p_addr));
            end
            if (p_dv && !p_dr) chk("data_hold", {31'd0, data_valid, data}, {31'd0, 1'b1, p_data});
            if (hdr_valid && hdr_ready) begin
                chk("hdr_expected", 64'(hq.size() != 0), 1);
                if (hq.size() != 0) begin
                    ch = hq.pop_front();
                    chk("hdr_type", 64'(hdr_type), 64'(ch.typ));
                    if (ch.has_addr) chk("hdr_addr", 64'(hdr_addr), 64'(ch.addr));
                    chk("hdr_len", 64'(hdr_len), 64'(ch.len));
                    chk("hdr_tag", 64'(hdr_tag), 64'(ch.tag));
                    chk("hdr_req_id", 64'(hdr_req_id), 64'(ch.rid));
                    chk("hdr_be_first", 64'(hdr_be_first), 64'(ch.bf));
                    chk("hdr_be_last", 64'(hdr_be_last), 64'(ch.bl));
                    chk("hdr_bar", 64'(hdr_bar), 64'(ch.bar));
                end
                last_htype = hdr_type; last_haddr = hdr_addr; last_hlen = hdr_len;
                last_htag = hdr_tag; last_hbar = hdr_bar;
            end
            if (data_valid && data_ready) begin
                chk("data_expected", 64'(dq.size() != 0), 1);
                if (dq.size() != 0) begin
                    cd = dq.pop_front();
                    if (!cd.dc) chk("data", 64'(data), 64'(cd.d));
                    chk("data_last", 64'(data_last), 64'(cd.last));
                    chk("data_err", 64'(data_err), 64'(cd.err));
                end
                last_data = data; last_dlast = data_last; last_derr = data_err;
            end
            p_hv <= hdr_valid; p_hr <= hdr_ready; p_addr <= hdr_addr;
            p_dv <= data_valid; p_dr <= data_ready; p_data <= data;
        end
    end

    initial begin
        data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            data_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        int n;
        rst = 1'b1; trn_rd = '0; hdr_ready = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdst_rdy_n", 64'(trn_rdst_rdy_n), 1);
        chk("rst_hdr_bar", 64'(hdr_bar), 7);
        chk("rst_hdr_valid", 64'(hdr_valid), 0);
        chk("rst_data_valid", 64'(data_valid), 0);
        chk("rst_drop_count", 64'(drop_count), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // MWr 3DW, len 2, BAR0
        tx = '{32'h40000002, 32'h0000010F, 32'h00001000, 32'hA5A5A5A5, 32'h5A5A5A5A};
        send(1, -1, 7'b1111110, 0);
        drain("mwr3");
        chk("mwr3_type", 64'(last_htype), 1);
        chk("mwr3_len", 64'(last_hlen), 2);
        chk("mwr3_addr", 64'(last_haddr), 64'h400);
        chk("mwr3_tag", 64'(last_htag), 1);
        chk("mwr3_bar", 64'(last_hbar), 0);
        chk("mwr3_last_data", 64'(last_data), 64'h5A5A5A5A);
        chk("mwr3_last_flags", {62'd0, last_dlast, last_derr}, 64'b10);

        // MRd 4DW, len 0, header stalled 5 cycles
        hdr_ready = 1'b0;
        tx = '{32'h20000000, 32'h123405FF, 32'h00000001, 32'h23456780};
        send(1, -1, 7'b1111101, 0);
        n = 0;
        while (!hdr_valid && n < 50) begin @(negedge clk); n++; end
        chk("mrd_hdr_valid_seen", 64'(hdr_valid), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mrd_stall_rdst", 64'(trn_rdst_rdy_n), 1);
        end
        @(posedge clk); #1;
        hdr_ready = 1'b1;
        drain("mrd4");
        chk("mrd4_len", 64'(last_hlen), 1024);
        chk("mrd4_addr", 64'(last_haddr), 64'h48D159E0);

        // Msg (unsupported) then CplD len 1
        tx = '{32'h30000000, 32'h00000000, 32'h00000000, 32'h00000000};
        send(1, -1, 7'h7F, 0);
        tx = '{32'h4A000001, 32'hABCD0004, 32'h0100070C, 32'hDEADBEEF};
        send(1, -1, 7'h7F, 0);
        drain("msg_cpld");
        chk("msg_drop_count", 64'(drop_count), 1);
        chk("cpld_type", 64'(last_htype), 3);

        // Discontinue on 3rd payload beat of len-8 MWr, then a clean MWr
        tx = '{32'h40000008, 32'h0000020F, 32'h00002000};
        for (int k = 0; k < 8; k++) tx.push_back(32'h11110000 + k);
        send(1, 5, 7'b1111110, 0);
        drain("dsc");
        chk("dsc_flags", {62'd0, last_dlast, last_derr}, 64'b11);
        chk("dsc_drop_count", 64'(drop_count), 2);
        tx = '{32'h40000001, 32'h0000030F, 32'h00003000, 32'hCAFEF00D};
        send(1, -1, 7'b1111110, 0);
        drain("after_dsc");
        chk("after_dsc_flags", {62'd0, last_dlast, last_derr}, 64'b10);

        // Length mismatch: short CplD, then over-long MWr
        tx = '{32'h4A000004, 32'h55550010, 32'h01000904, 32'h00000001, 32'h00000002};
        send(1, -1, 7'h7F, 0);
        tx = '{32'h40000002, 32'h0000040F, 32'h00004000, 32'hB0, 32'hB1, 32'hB2, 32'hB3};
        send(1, -1, 7'b1111110, 0);
        drain("len_mismatch");
        chk("len_mismatch_drops", 64'(drop_count), 4);

        // Poisoned MWr and MWr ending on its last header DW
        tx = '{32'h40000001, 32'h0000050F, 32'h00005000, 32'h0BADBAD0};
        send(1, -1, 7'b1111110, 1);
        tx = '{32'h40000001, 32'h0000060F, 32'h00006000};
        send(1, -1, 7'b1111110, 0);
        drain("poison_short");

        // 4DW MWr under random payload backpressure, lowest of several BAR hits
        bp_mode = 1'b1;
        tx = '{32'h60000006, 32'h00AB12F3, 32'h00000002, 32'h00000040};
        for (int k = 0; k < 6; k++) tx.push_back(32'hC0DE0000 + k * 3);
        send(1, -1, 7'b0100111, 0);
        drain("bp");
        bp_mode = 1'b0;
        chk("bp_bar", 64'(last_hbar), 3);

        // Reset mid-payload, junk without SOF, then fresh MWr
        tx = '{32'h40000008, 32'h0000070F, 32'h00007000, 32'h1, 32'h2, 32'h3};
        send(0, -1, 7'b1111110, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_reset_data_left", 64'(dq.size()), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hq.delete(); dq.delete();
        exp_drops = 0;
        for (int k = 0; k < 3; k++) begin
            trn_rd = 32'hDEAD0000 + k; trn_rsrc_rdy_n = 1'b0;
            @(posedge clk); #1;
        end
        idle_inputs();
        tx = '{32'h40000003, 32'h00FF22FF, 32'h0000ABC0, 32'h77, 32'h88, 32'h99};
        send(1, -1, 7'b1111011, 0);
        drain("post_reset");
        chk("post_reset_bar", 64'(last_hbar), 2);
        chk("post_reset_last_data", 64'(last_data), 64'h99);

        // Saturation: one SOF+EOF drop per cycle
        trn_rd = 32'h00000001; trn_rsof_n = 1'b0; trn_reof_n = 1'b0; trn_rsrc_rdy_n = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        idle_inputs();
        exp_drops += 65540;
        drain("saturate");
        chk("saturate_literal", 64'(drop_count), 64'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
